// File: rtl/tcdm_rsp_pkg.sv
// Shared definitions for the TCDM response-return path.
//  - idx_width(): master index width, at least 1 bit
//  - cnt_width(): outstanding counter width (must hold 0..depth)
//  - err_cause_e: classification of protocol errors feeding err_o
package tcdm_rsp_pkg;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_OVERFLOW  = 2'd1,
      ERR_UNDERFLOW = 2'd2,
      ERR_BAD_IDX   = 2'd3
   } err_cause_e;

endpackage

// File: rtl/tcdm_idx_fifo.sv
// In-order FIFO of granted master indices.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i / data_i    write an index (ignored when full unless popping)
//   pop_i  / data_o    retire the head entry (ignored when empty)
//   full_o, empty_o    derived from the registered count
//   cnt_o              number of stored entries
// Depth must be a power of two so the pointers wrap for free.
module tcdm_idx_fifo import tcdm_rsp_pkg::*; #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [Width-1:0]         data_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   cnt_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = cnt_width(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;
   assign data_o  = mem_q[rptr_q];

   // A pop in the same cycle frees the slot, so a push into a full FIFO is
   // still accepted then.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wptr_d = wptr_q + PtrW'(do_push);
      rptr_d = rptr_q + PtrW'(do_pop);
      cnt_d  = cnt_q;
      if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
      if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset: only entries below cnt_q are ever read out.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/tcdm_rsp_return.sv
// Response-return path for a round-robin TCDM arbitration tree.
// Every grant pushes the master index into an in-order FIFO; every slave
// response pops the head and is steered back to that master.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_fire_i, req_idx_i    arbiter handshake and granted master index
//   rsp_valid_i, rsp_data_i  slave response (always accepted)
//   rsp_valid_o, rsp_data_o  per-master one-hot valid and data
//   full_o, empty_o, cnt_o   outstanding-transaction status (gate gnt with ~full_o)
//   err_o                    sticky overflow / underflow / bad-index error
// Build option: TCDM_RSP_REG_OUT_EN registers rsp_valid_o/rsp_data_o
// (one cycle latency, unselected masters hold their data). Otherwise the
// outputs are combinational and rsp_data_i is broadcast to all masters.
module tcdm_rsp_return import tcdm_rsp_pkg::*; #(
   parameter  int unsigned NumReq         = 32,
   parameter  int unsigned DataWidth      = 32,
   parameter  int unsigned MaxOutstanding = 4,
   localparam int unsigned IdxWidth       = idx_width(NumReq),
   localparam int unsigned CntWidth       = cnt_width(MaxOutstanding)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             req_fire_i,
   input  logic [IdxWidth-1:0]              req_idx_i,
   input  logic                             rsp_valid_i,
   input  logic [DataWidth-1:0]             rsp_data_i,
   output logic [NumReq-1:0]                rsp_valid_o,
   output logic [NumReq-1:0][DataWidth-1:0] rsp_data_o,
   output logic                             full_o,
   output logic                             empty_o,
   output logic [CntWidth-1:0]              cnt_o,
   output logic                             err_o
);

   logic [IdxWidth-1:0] head_idx;
   logic                fifo_full, fifo_empty;
   logic                pop_ok, idx_bad;
   logic [NumReq-1:0]   rsp_sel;
   err_cause_e          err_cause;
   logic                err_q, err_d;

   tcdm_idx_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdxWidth)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (req_fire_i),
      .data_i  (req_idx_i),
      .pop_i   (rsp_valid_i),
      .data_o  (head_idx),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .cnt_o   (cnt_o)
   );

   assign full_o  = fifo_full;
   assign empty_o = fifo_empty;
   // No fall-through: a same-cycle push never satisfies a response.
   assign pop_ok  = rsp_valid_i & ~fifo_empty;

   // Out-of-range indices are only representable when NumReq is not a power of two.
   if (NumReq == (1 << IdxWidth)) begin : g_idx_full_range
      assign idx_bad = 1'b0;
   end else begin : g_idx_range_chk
      assign idx_bad = (head_idx >= IdxWidth'(NumReq));
   end

   always_comb begin
      rsp_sel = '0;
      for (int i = 0; i < NumReq; i++) begin
         rsp_sel[i] = pop_ok & ~idx_bad & (head_idx == IdxWidth'(i));
      end
   end

   // Overflow needs a full FIFO and underflow an empty one, and a bad index
   // needs a pop, so the causes are mutually exclusive.
   always_comb begin
      err_cause = ERR_NONE;
      if (req_fire_i && fifo_full && !pop_ok) err_cause = ERR_OVERFLOW;
      else if (rsp_valid_i && fifo_empty)     err_cause = ERR_UNDERFLOW;
      else if (pop_ok && idx_bad)             err_cause = ERR_BAD_IDX;
      err_d = err_q | (err_cause != ERR_NONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= err_d;
   end
   assign err_o = err_q;

`ifdef TCDM_RSP_REG_OUT_EN
   logic [NumReq-1:0]                rsp_valid_q;
   logic [NumReq-1:0][DataWidth-1:0] rsp_data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_sel;
         for (int i = 0; i < NumReq; i++) begin
            if (rsp_sel[i]) rsp_data_q[i] <= rsp_data_i;
         end
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
`else
   assign rsp_valid_o = rsp_sel;
   assign rsp_data_o  = {NumReq{rsp_data_i}};
`endif

   a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_o <= CntWidth'(MaxOutstanding));

endmodule

// File: tb/tb_tcdm_rsp_return.sv
module tb_tcdm_rsp_return;
   import tcdm_rsp_pkg::*;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int MO = 4;
   localparam int IW = 2;
   localparam int CW = 3;
`ifdef TCDM_RSP_REG_OUT_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic                     clk_i = 1'b0;
   logic                     rst_ni = 1'b0;
   logic                     req_fire_i = 1'b0;
   logic [IW-1:0]            req_idx_i = '0;
   logic                     rsp_valid_i = 1'b0;
   logic [DW-1:0]            rsp_data_i = '0;
   logic [NR-1:0]            rsp_valid_o;
   logic [NR-1:0][DW-1:0]    rsp_data_o;
   logic                     full_o, empty_o, err_o;
   logic [CW-1:0]            cnt_o;

   always #5 clk_i = ~clk_i;

   tcdm_rsp_return #(
      .NumReq         (NR),
      .DataWidth      (DW),
      .MaxOutstanding (MO)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_fire_i  (req_fire_i),
      .req_idx_i   (req_idx_i),
      .rsp_valid_i (rsp_valid_i),
      .rsp_data_i  (rsp_data_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_data_o  (rsp_data_o),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .cnt_o       (cnt_o),
      .err_o       (err_o)
   );

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t exp_q[$];     // scoreboard: expected responses in order
   int   model_q[$];   // reference: outstanding master indices
   bit   model_err;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: consumes expected responses whenever the DUT presents one.
   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_ni) begin
         if (rsp_valid_o != '0) chk("rsp_in_reset", 64'(rsp_valid_o), 64'd0);
      end else if (rsp_valid_o != '0) begin
         if (exp_q.size() == 0) begin
            chk("spurious_rsp", 64'(rsp_valid_o), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_valid", 64'(rsp_valid_o), 64'(1 << e.idx));
            chk("rsp_data", 64'(rsp_data_o[e.idx]), 64'(e.data));
            chk("rsp_latency", 64'(cyc), 64'(e.due));
`ifndef TCDM_RSP_REG_OUT_EN
            chk("rsp_bcast", 64'(rsp_data_o[(e.idx + 1) % NR]), 64'(e.data));
`endif
         end
      end
   end

   task automatic chk_status(input string tag);
      chk({tag, "_cnt"},   64'(cnt_o),   64'(model_q.size()));
      chk({tag, "_full"},  64'(full_o),  64'(model_q.size() == MO));
      chk({tag, "_empty"}, 64'(empty_o), 64'(model_q.size() == 0));
      chk({tag, "_err"},   64'(err_o),   64'(model_err));
   endtask

   // One clock of stimulus; the model predicts the response and next state.
   task automatic cycle(input bit push, input int idx, input bit rsp, input logic [DW-1:0] data);
      exp_t e;
      bit   pop_ok;
      req_fire_i  = push;
      req_idx_i   = idx[IW-1:0];
      rsp_valid_i = rsp;
      rsp_data_i  = data;
      pop_ok = rsp && (model_q.size() > 0);
      if (rsp && !pop_ok) model_err = 1'b1;
      if (pop_ok) begin
         e.idx  = model_q.pop_front();
         e.data = data;
         e.due  = cyc + LAT;
         exp_q.push_back(e);
      end
      if (push) begin
         if (model_q.size() < MO) model_q.push_back(idx);
         else                     model_err = 1'b1;
      end
      @(posedge clk_i); #1;
      req_fire_i  = 1'b0;
      rsp_valid_i = 1'b0;
      chk_status("status");
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      model_q.delete();
      model_err = 1'b0;
      #1;
      chk_status("reset");
      chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      bit push, rsp;
      #1;
      chk_status("por");
      chk("por_rsp_valid", 64'(rsp_valid_o), 64'd0);
`ifdef TCDM_RSP_REG_OUT_EN
      chk("por_rsp_data", 64'(rsp_data_o[1]), 64'd0);
`endif
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // Directed: push 2,0,3 then three responses.
      cycle(1, 2, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 3, 0, 0);
      cycle(0, 0, 1, 32'hA);
      cycle(0, 0, 1, 32'hB);
      cycle(0, 0, 1, 32'hC);
      cycle(0, 0, 0, 0);

      // Fill, push+pop while full, then overflow.
      for (int i = 0; i < MO; i++) cycle(1, $urandom_range(0, NR-1), 0, 0);
      cycle(1, 1, 1, 32'h1234_5678);
      cycle(1, 2, 0, 0);
      for (int i = 0; i < MO; i++) cycle(0, 0, 1, $urandom);
      cycle(0, 0, 0, 0);
      do_reset();

      // Response with nothing outstanding.
      cycle(0, 0, 1, 32'hDEAD);
      cycle(1, 3, 1, 32'hBEEF);   // same-cycle push must not satisfy it
      cycle(0, 0, 1, 32'h77);
      cycle(0, 0, 0, 0);
      do_reset();

      // Legal random traffic; wraps the pointers many times.
      for (int i = 0; i < 300; i++) begin
         rsp  = (model_q.size() > 0) && ($urandom_range(0, 2) != 0);
         push = ($urandom_range(0, 2) != 0) && ((model_q.size() < MO) || rsp);
         cycle(push, $urandom_range(0, NR-1), rsp, $urandom);
      end
      while (model_q.size() > 0) cycle(0, 0, 1, $urandom);
      cycle(0, 0, 0, 0);

      // Reset with three outstanding: they must be discarded.
      cycle(1, 1, 0, 0);
      cycle(1, 2, 0, 0);
      cycle(1, 3, 0, 0);
      do_reset();
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 32'h5A5A);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
